// File: rtl/m_demux_credit_ctrl.sv
// Packet-locking 1:2 demux controller with per-output credit flow control.
// A head flit locks the path to one output until its tail flit has passed.
module m_demux_credit_ctrl #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_CREDITS    = 4,
  parameter int P_CNT_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_head,
  input  logic                    in_tail,
  input  logic                    in_dest,
  input  logic [P_DATA_WIDTH-1:0] in_data,
  input  logic                    credit_in_0,
  input  logic                    credit_in_1,
  output logic                    select,
  output logic [P_DATA_WIDTH-1:0] data_out,
  output logic                    valid_0,
  output logic                    valid_1,
  output logic                    busy,
  output logic                    err
);

  localparam logic [P_CNT_WIDTH-1:0] LP_MAX = P_CNT_WIDTH'(P_CREDITS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_0 = 2'd1,
    ST_LOCK_1 = 2'd2
  } state_t;

  state_t                    r_state;
  logic [P_CNT_WIDTH-1:0]    r_cnt_0;
  logic [P_CNT_WIDTH-1:0]    r_cnt_1;
  logic                      r_select;
  logic [P_DATA_WIDTH-1:0]   r_data_out;
  logic                      r_valid_0;
  logic                      r_valid_1;
  logic                      r_err;

  logic w_tgt;
  logic w_credit_ok;
  logic w_accept;
  logic w_discard;
  logic w_fwd;
  logic w_dec_0;
  logic w_dec_1;
  logic w_ovf_0;
  logic w_ovf_1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_tgt = in_dest;
    case (r_state)
      ST_LOCK_0: w_tgt = 1'b0;
      ST_LOCK_1: w_tgt = 1'b1;
      default:   w_tgt = in_dest;
    endcase
  end

  assign w_credit_ok = w_tgt ? (r_cnt_1 != '0) : (r_cnt_0 != '0);
  // A stray body flit in IDLE is always accepted so it can be dropped.
  assign in_ready    = ((r_state == ST_IDLE) && !in_head) || w_credit_ok;
  assign w_accept    = in_valid && in_ready;
  assign w_discard   = w_accept && (r_state == ST_IDLE) && !in_head;
  assign w_fwd       = w_accept && !w_discard;

  assign w_dec_0 = w_fwd && !w_tgt;
  assign w_dec_1 = w_fwd &&  w_tgt;
  assign w_ovf_0 = credit_in_0 && !w_dec_0 && (r_cnt_0 == LP_MAX);
  assign w_ovf_1 = credit_in_1 && !w_dec_1 && (r_cnt_1 == LP_MAX);

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt_0    <= LP_MAX;
      r_cnt_1    <= LP_MAX;
      r_select   <= 1'b0;
      r_data_out <= '0;
      r_valid_0  <= 1'b0;
      r_valid_1  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_valid_0 <= w_dec_0;
      r_valid_1 <= w_dec_1;
      if (w_fwd) begin
        r_select   <= w_tgt;
        r_data_out <= in_data;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_fwd && !in_tail) r_state <= in_dest ? ST_LOCK_1 : ST_LOCK_0;
        end
        ST_LOCK_0, ST_LOCK_1: begin
          if (w_accept && in_tail) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Simultaneous consume and return cancel out; a return at full saturates.
      if (w_dec_0 && !credit_in_0)                           r_cnt_0 <= r_cnt_0 - 1'b1;
      else if (credit_in_0 && !w_dec_0 && r_cnt_0 != LP_MAX) r_cnt_0 <= r_cnt_0 + 1'b1;

      if (w_dec_1 && !credit_in_1)                           r_cnt_1 <= r_cnt_1 - 1'b1;
      else if (credit_in_1 && !w_dec_1 && r_cnt_1 != LP_MAX) r_cnt_1 <= r_cnt_1 + 1'b1;

      r_err <= r_err | w_discard | w_ovf_0 | w_ovf_1;
    end
  end

  assign select   = r_select;
  assign data_out = r_data_out;
  assign valid_0  = r_valid_0;
  assign valid_1  = r_valid_1;
  assign busy     = (r_state != ST_IDLE);
  assign err      = r_err;

endmodule
